// File: rtl/module_modcounter_pkg.sv
// Shared types and limits for the modulo counter slice.
// Direction and boundary-mode encodings plus the widest supported counter.
package counter_pkg;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;

    localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/module_modcounter_if.sv
// Control/status bundle for module_modcounter; master drives controls, slave is the counter.
// No backpressure: every field is sampled or presented each cycle.
interface module_modcounter_if #(
    parameter int WIDTH = 4
);
    logic             stop;
    logic             dir;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;
    logic             load_err;

    modport master (
        output stop, dir, sat_mode, load, load_val, clr_ovf,
        input  count, tc, wrap, ovf, load_err
    );

    modport slave (
        input  stop, dir, sat_mode, load, load_val, clr_ovf,
        output count, tc, wrap, ovf, load_err
    );
endinterface

// File: rtl/module_modcounter_count_next.sv
// Next-state logic for the modulo counter: next count plus wrap and load-error events.
// Purely combinational, zero latency; no backpressure.
module module_count_next
    import counter_pkg::*;
#(
    parameter int             WIDTH = 4,
    parameter logic [WIDTH:0] MAX_C = '1
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_dir,
    input  logic             i_sat_mode,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap_evt,
    output logic             o_load_err_evt
);
    // Comparisons are done one bit wider so MAX_C = 2**WIDTH-1 never truncates.
    logic [WIDTH:0] w_cnt_ext;
    logic [WIDTH:0] w_lv_ext;
    logic           w_sat;

    assign w_cnt_ext = {1'b0, i_count};
    assign w_lv_ext  = {1'b0, i_load_val};
    assign w_sat     = (mode_e'(i_sat_mode) == MODE_SAT);

    always_comb begin
        o_next         = i_count;
        o_wrap_evt     = 1'b0;
        o_load_err_evt = 1'b0;
        if (i_load) begin
            if (w_lv_ext > MAX_C) begin
                o_next         = MAX_C[WIDTH-1:0];
                o_load_err_evt = 1'b1;
            end else begin
                o_next = i_load_val;
            end
        end else if (!i_stop) begin
            if (dir_e'(i_dir) == DIR_DOWN) begin
                if (w_cnt_ext == '0) begin
                    o_wrap_evt = 1'b1;
                    o_next     = w_sat ? i_count : MAX_C[WIDTH-1:0];
                end else begin
                    o_next = i_count - WIDTH'(1);
                end
            end else begin
                if (w_cnt_ext >= MAX_C) begin
                    o_wrap_evt = 1'b1;
                    o_next     = w_sat ? i_count : '0;
                end else begin
                    o_next = i_count + WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: rtl/module_modcounter.sv
// N-bit modulo up/down counter with load, hold, wrap/saturate, tc/wrap/load_err pulses and sticky ovf.
// Count and pulses update one edge after the inputs; tc is combinational; no backpressure.
module module_modcounter
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter longint unsigned RST_VAL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    module_modcounter_if.slave     bus
);
    localparam logic [WIDTH:0] MAX_C = (WIDTH+1)'(MODULUS - 64'd1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("module_modcounter: WIDTH out of range 1..%0d", MAX_WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("module_modcounter: MODULUS out of range 2..2**WIDTH");
    end
    if (RST_VAL >= MODULUS) begin : g_bad_rst_val
        $error("module_modcounter: RST_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;
    logic             r_load_err;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_evt;
    logic             w_load_err_evt;

    module_count_next #(
        .WIDTH (WIDTH),
        .MAX_C (MAX_C)
    ) u_next (
        .i_count        (r_count),
        .i_dir          (bus.dir),
        .i_sat_mode     (bus.sat_mode),
        .i_load         (bus.load),
        .i_load_val     (bus.load_val),
        .i_stop         (bus.stop),
        .o_next         (w_next),
        .o_wrap_evt     (w_wrap_evt),
        .o_load_err_evt (w_load_err_evt)
    );

    // A wrap on the same edge as clr_ovf keeps ovf set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= WIDTH'(RST_VAL);
            r_wrap     <= 1'b0;
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_wrap     <= w_wrap_evt;
            r_load_err <= w_load_err_evt;
            if (w_wrap_evt) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.count    = r_count;
    assign bus.wrap     = r_wrap;
    assign bus.ovf      = r_ovf;
    assign bus.load_err = r_load_err;
    assign bus.tc       = (dir_e'(bus.dir) == DIR_DOWN) ? (r_count == '0)
                                                        : ({1'b0, r_count} == MAX_C);
endmodule

// File: tb/tb_module_modcounter.sv
// Bench for module_modcounter: a mod-10 and a mod-4 (full-range) instance against an arithmetic model.
module tb_module_modcounter;
    localparam int MA = 10;
    localparam int RA = 0;
    localparam int MB = 4;
    localparam int RB = 3;

    typedef struct {
        int cnt;
        bit wrap;
        bit ovf;
        bit lerr;
    } mst_t;

    logic clk;
    logic rst_a;
    logic rst_b;

    module_modcounter_if #(.WIDTH(4)) ifa ();
    module_modcounter_if #(.WIDTH(2)) ifb ();

    module_modcounter #(.WIDTH(4), .MODULUS(MA), .RST_VAL(RA)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    module_modcounter #(.WIDTH(2), .MODULUS(MB), .RST_VAL(RB)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    bit a_rst, a_stop, a_dir, a_sat, a_load, a_clr;
    int a_lv;
    bit b_rst, b_stop, b_dir, b_sat, b_load, b_clr;
    int b_lv;
    mst_t ma, mb;

    // Counting modulo m: a step that leaves 0..m-1 is a boundary event.
    function automatic mst_t mnext(mst_t s, int m, int rstv, bit rst, bit stop, bit dir,
                                   bit sat, bit load, int lv, bit clr);
        mst_t n;
        int   t;
        n      = s;
        n.wrap = 1'b0;
        n.lerr = 1'b0;
        if (rst) begin
            n.cnt = rstv;
            n.ovf = 1'b0;
            return n;
        end
        if (load) begin
            if (lv >= m) begin
                n.cnt  = m - 1;
                n.lerr = 1'b1;
            end else begin
                n.cnt = lv;
            end
        end else if (!stop) begin
            t = s.cnt + (dir ? -1 : 1);
            if (t < 0 || t >= m) begin
                n.wrap = 1'b1;
                n.cnt  = sat ? s.cnt : (t + m) % m;
            end else begin
                n.cnt = t;
            end
        end
        if (n.wrap) n.ovf = 1'b1;
        else if (clr) n.ovf = 1'b0;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        rst_a        = a_rst;
        ifa.stop     = a_stop;
        ifa.dir      = a_dir;
        ifa.sat_mode = a_sat;
        ifa.load     = a_load;
        ifa.load_val = 4'(a_lv);
        ifa.clr_ovf  = a_clr;
        rst_b        = b_rst;
        ifb.stop     = b_stop;
        ifb.dir      = b_dir;
        ifb.sat_mode = b_sat;
        ifb.load     = b_load;
        ifb.load_val = 2'(b_lv);
        ifb.clr_ovf  = b_clr;
        ma = mnext(ma, MA, RA, a_rst, a_stop, a_dir, a_sat, a_load, a_lv, a_clr);
        mb = mnext(mb, MB, RB, b_rst, b_stop, b_dir, b_sat, b_load, b_lv, b_clr);
        @(posedge clk);
        #1;
        chk("a_count", 32'(ifa.count), ma.cnt);
        chk("a_wrap", 32'(ifa.wrap), int'(ma.wrap));
        chk("a_ovf", 32'(ifa.ovf), int'(ma.ovf));
        chk("a_load_err", 32'(ifa.load_err), int'(ma.lerr));
        chk("a_tc", 32'(ifa.tc), int'(a_dir ? (ma.cnt == 0) : (ma.cnt == MA - 1)));
        chk("b_count", 32'(ifb.count), mb.cnt);
        chk("b_wrap", 32'(ifb.wrap), int'(mb.wrap));
        chk("b_ovf", 32'(ifb.ovf), int'(mb.ovf));
        chk("b_tc", 32'(ifb.tc), int'(b_dir ? (mb.cnt == 0) : (mb.cnt == MB - 1)));
    endtask

    initial begin
        a_rst = 1; a_stop = 0; a_dir = 0; a_sat = 0; a_load = 0; a_lv = 0; a_clr = 0;
        b_rst = 1; b_stop = 0; b_dir = 0; b_sat = 0; b_load = 0; b_lv = 0; b_clr = 0;
        ma = '{cnt: 0, wrap: 0, ovf: 0, lerr: 0};
        mb = '{cnt: 0, wrap: 0, ovf: 0, lerr: 0};
        tick();
        chk("reset_a_count", 32'(ifa.count), 0);
        chk("reset_b_count", 32'(ifb.count), 3);

        // Free count up through the mod-10 boundary.
        a_rst = 0;
        for (int i = 0; i < 11; i++) tick();
        chk("wrap_run_count", 32'(ifa.count), 1);
        chk("wrap_run_ovf", 32'(ifa.ovf), 1);

        // Down-saturate from 2, then clear ovf while stopped.
        a_load = 1; a_lv = 2; tick();
        a_load = 0; a_dir = 1; a_sat = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("sat_hold_count", 32'(ifa.count), 0);
        chk("sat_hold_wrap", 32'(ifa.wrap), 1);
        a_stop = 1; a_clr = 1; tick();
        chk("clr_ovf", 32'(ifa.ovf), 0);
        a_clr = 0;

        // Loads while stopped: legal, then out of range.
        a_load = 1; a_lv = 7; tick();
        chk("load7", 32'(ifa.count), 7);
        a_lv = 12; tick();
        chk("load12_count", 32'(ifa.count), 9);
        chk("load12_err", 32'(ifa.load_err), 1);
        a_lv = 0; a_load = 0; tick();
        chk("load_err_pulse", 32'(ifa.load_err), 0);

        // Wrap and clr_ovf on the same edge.
        a_load = 1; a_lv = 9; tick();
        a_load = 0; a_stop = 0; a_dir = 0; a_sat = 0; a_clr = 1; tick();
        chk("set_wins_ovf", 32'(ifa.ovf), 1);
        a_clr = 0;

        // Reset beats a simultaneous load.
        a_load = 1; a_lv = 5; tick();
        a_rst = 1; a_lv = 3; tick();
        chk("rst_over_load", 32'(ifa.count), 0);
        a_rst = 0; a_load = 0; a_stop = 1;
        for (int i = 0; i < 5; i++) tick();

        // Full-range mod-4 instance counting from 3.
        b_rst = 0;
        tick();
        chk("b_wrap_to_0", 32'(ifb.count), 0);
        for (int i = 0; i < 5; i++) tick();

        for (int i = 0; i < 400; i++) begin
            a_rst  = ($urandom_range(0, 49) == 0);
            a_stop = ($urandom_range(0, 3) == 0);
            a_dir  = 1'($urandom);
            a_sat  = 1'($urandom);
            a_load = ($urandom_range(0, 7) == 0);
            a_lv   = int'($urandom_range(0, 15));
            a_clr  = ($urandom_range(0, 7) == 0);
            b_rst  = ($urandom_range(0, 49) == 0);
            b_stop = ($urandom_range(0, 3) == 0);
            b_dir  = 1'($urandom);
            b_sat  = 1'($urandom);
            b_load = ($urandom_range(0, 7) == 0);
            b_lv   = int'($urandom_range(0, 3));
            b_clr  = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
